// File: rtl/pixel_stream_source_if.sv
`default_nettype none
// ============================================================================
// Module      : pixel_stream_source_if
// Description : Bundles the host write port, the stream control inputs and
//               the raster pixel stream outputs of pixel_stream_source.
//               master : host / testbench side (drives writes and control)
//               slave  : pixel_stream_source side (drives the stream)
//   wr_en/wr_addr/wr_data : frame-memory write port
//   start/row_gap/pause   : stream control
//   valid_out/pixel_out/sof_out/eol_out/last_out/busy : pixel stream + status
// Revision    : 1.0 - initial release
// ============================================================================
interface pixel_stream_source_if #(
    parameter int ADDR_W = 14
) ();
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              start;
    logic [7:0]        row_gap;
    logic              pause;
    logic              valid_out;
    logic [7:0]        pixel_out;
    logic              sof_out;
    logic              eol_out;
    logic              last_out;
    logic              busy;

    modport master (
        output wr_en, wr_addr, wr_data, start, row_gap, pause,
        input  valid_out, pixel_out, sof_out, eol_out, last_out, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, row_gap, pause,
        output valid_out, pixel_out, sof_out, eol_out, last_out, busy
    );
endinterface
`default_nettype wire

// File: rtl/pixel_stream_source.sv
`default_nettype none
// ============================================================================
// Module      : pixel_stream_source
// Description : Frame-buffered raster pixel transmitter. A host loads one
//               WIDTH x HEIGHT frame of 8-bit pixels through a write port;
//               a start request replays it row-major, one pixel per cycle,
//               with optional idle gaps between rows and a pause input.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - pixel_stream_source_if.slave (write port, control,
//                      valid/pixel/sof/eol/last stream, busy)
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_stream_source #(
    parameter int WIDTH  = 128,
    parameter int HEIGHT = 128,
    parameter int ADDR_W = 14
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    pixel_stream_source_if.slave        bus
);

    localparam int DEPTH  = WIDTH * HEIGHT;
    localparam int MEM_AW = (DEPTH  > 1) ? $clog2(DEPTH)  : 1;
    localparam int COL_W  = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_GAP    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [7:0]         gap_len_q, gap_len_d;
    logic [7:0]         gap_cnt_q, gap_cnt_d;
    logic               valid_q, valid_d;
    logic               sof_q, sof_d;
    logic               eol_q, eol_d;
    logic               last_q, last_d;

    logic               rd_en;
    logic [MEM_AW-1:0]  rd_addr;
    logic               col_last;
    logic               row_last;
    logic               wr_ok;
    logic [7:0]         pixel_q;

    // Frame store: deliberately not reset so a loaded frame survives rst.
    logic [7:0]         mem [0:DEPTH-1];

    assign col_last = (col_q == COL_W'(WIDTH - 1));
    assign row_last = (row_q == ROW_W'(HEIGHT - 1));

    // Linear read address. MEM_AW bits always hold row*WIDTH+col without
    // overflow because the largest value is DEPTH-1.
    assign rd_addr  = MEM_AW'(row_q) * MEM_AW'(WIDTH) + MEM_AW'(col_q);

    // Host writes only land while idle and inside the frame.
    assign wr_ok    = bus.wr_en && (state_q == S_IDLE)
                      && (32'(bus.wr_addr) < 32'(DEPTH));

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        gap_len_d = gap_len_q;
        gap_cnt_d = gap_cnt_q;
        valid_d   = 1'b0;
        sof_d     = 1'b0;
        eol_d     = 1'b0;
        last_d    = 1'b0;
        rd_en     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_STREAM;
                    col_d     = '0;
                    row_d     = '0;
                    gap_len_d = bus.row_gap;
                    gap_cnt_d = '0;
                end
            end

            S_STREAM: begin
                if (!bus.pause) begin
                    rd_en   = 1'b1;
                    valid_d = 1'b1;
                    sof_d   = (row_q == '0) && (col_q == '0);
                    eol_d   = col_last;
                    last_d  = col_last && row_last;
                    if (col_last) begin
                        col_d = '0;
                        if (row_last) begin
                            row_d   = '0;
                            state_d = S_IDLE;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                            if (gap_len_q != 8'd0) begin
                                state_d = S_GAP;
                            end
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end

            S_GAP: begin
                // Stays here exactly gap_len cycles; pause has no effect.
                if (gap_cnt_q == gap_len_q - 8'd1) begin
                    gap_cnt_d = '0;
                    state_d   = S_STREAM;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            gap_len_q <= '0;
            gap_cnt_q <= '0;
            valid_q   <= 1'b0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            gap_len_q <= gap_len_d;
            gap_cnt_q <= gap_cnt_d;
            valid_q   <= valid_d;
            sof_q     <= sof_d;
            eol_q     <= eol_d;
            last_q    <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[bus.wr_addr[MEM_AW-1:0]] <= bus.wr_data;
        end
    end

    // Synchronous read straight into the output register; holds whenever no
    // pixel is emitted (pause, gap, idle).
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_q <= '0;
        end else if (rd_en) begin
            pixel_q <= mem[rd_addr];
        end
    end

    assign bus.valid_out = valid_q;
    assign bus.pixel_out = pixel_q;
    assign bus.sof_out   = sof_q;
    assign bus.eol_out   = eol_q;
    assign bus.last_out  = last_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_stream_source
// Description : Self-checking bench for pixel_stream_source with a 4x3 frame.
//               A frame-level reference model (linear pixel index, gap and
//               pause bookkeeping) predicts every output each cycle; directed
//               sequences add literal expectations, then random traffic runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_stream_source;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 4;
    localparam int N  = W * H;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pixel_stream_source_if #(.ADDR_W(AW)) bus ();

    pixel_stream_source #(
        .WIDTH  (W),
        .HEIGHT (H),
        .ADDR_W (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL timeout %s actual=no-event expected=event at %0t", name, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: frame treated as a linear pixel sequence.
    // ------------------------------------------------------------------
    logic [7:0] ref_mem [N];
    bit         m_active;
    int         m_idx;
    int         m_gap_left;
    int         m_gaplen;
    logic       e_valid, e_sof, e_eol, e_last;
    logic [7:0] e_pix;

    always @(posedge clk) begin
        if (rst) begin
            m_active   = 1'b0;
            m_gap_left = 0;
            e_valid = 1'b0; e_sof = 1'b0; e_eol = 1'b0; e_last = 1'b0;
            e_pix   = 8'd0;
        end else begin
            if (bus.wr_en && !m_active && (int'(bus.wr_addr) < N))
                ref_mem[bus.wr_addr] = bus.wr_data;
            e_valid = 1'b0; e_sof = 1'b0; e_eol = 1'b0; e_last = 1'b0;
            if (!m_active) begin
                if (bus.start) begin
                    m_active   = 1'b1;
                    m_idx      = 0;
                    m_gaplen   = int'(bus.row_gap);
                    m_gap_left = 0;
                end
            end else if (m_gap_left > 0) begin
                m_gap_left--;
            end else if (!bus.pause) begin
                e_valid = 1'b1;
                e_pix   = ref_mem[m_idx];
                e_sof   = (m_idx == 0);
                e_eol   = (m_idx % W == W - 1);
                e_last  = (m_idx == N - 1);
                m_idx++;
                if (m_idx == N)  m_active   = 1'b0;
                else if (e_eol)  m_gap_left = m_gaplen;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid_out", bus.valid_out, e_valid);
            chk("busy",      bus.busy,      m_active);
            chk("pixel_out", bus.pixel_out, e_pix);
            chk("sof_out",   bus.sof_out,   e_sof);
            chk("eol_out",   bus.eol_out,   e_eol);
            chk("last_out",  bus.last_out,  e_last);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all act just after a falling edge)
    // ------------------------------------------------------------------
    task automatic pulse_start(input logic [7:0] gap);
        bus.row_gap = gap;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    task automatic wait_pix(input logic [7:0] v, input string name);
        for (int c = 0; c < 80; c++) begin
            if (bus.valid_out && bus.pixel_out == v) return;
            @(negedge clk);
        end
        timeout_fail(name);
    endtask

    task automatic wait_last(input string name);
        for (int c = 0; c < 80; c++) begin
            if (bus.last_out) return;
            @(negedge clk);
        end
        timeout_fail(name);
    endtask

    initial begin
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        bus.row_gap = '0;
        bus.pause   = 1'b0;
        repeat (3) @(negedge clk);

        chk("reset valid_out", bus.valid_out, 1'b0);
        chk("reset busy",      bus.busy,      1'b0);
        chk("reset pixel_out", bus.pixel_out, 8'd0);
        chk("reset last_out",  bus.last_out,  1'b0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Load mem[i] = i+10, then an out-of-frame write that must be dropped.
        for (int i = 0; i < N; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = AW'(i);
            bus.wr_data = 8'(i + 10);
            @(negedge clk);
        end
        bus.wr_addr = AW'(12);
        bus.wr_data = 8'hEE;
        @(negedge clk);
        bus.wr_en = 1'b0;
        @(negedge clk);

        // Frame 1: contiguous, literal expectations on every pixel.
        pulse_start(8'd0);
        chk("latency idle cycle", bus.valid_out, 1'b0);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk("f1 pixel", bus.pixel_out, 8'(10 + i));
            chk("f1 valid", bus.valid_out, 1'b1);
            chk("f1 sof",   bus.sof_out,  (i == 0));
            chk("f1 eol",   bus.eol_out,  (i % 4 == 3));
            chk("f1 last",  bus.last_out, (i == 11));
            chk("f1 busy",  bus.busy,     (i != 11));
            @(negedge clk);
        end
        chk("f1 after last valid", bus.valid_out, 1'b0);
        @(negedge clk);

        // Frame 2: row_gap=3 latched at start, then changed (must not matter).
        begin
            int span  = 0;
            int inval = 0;
            pulse_start(8'd3);
            bus.row_gap = 8'd0;
            for (int c = 0; c < 60; c++) begin
                if (bus.valid_out || span > 0) begin
                    span++;
                    if (!bus.valid_out) inval++;
                    if (bus.last_out) break;
                end
                @(negedge clk);
            end
            chk("f2 span",         span,  18);
            chk("f2 gap cycles",   inval, 6);
            @(negedge clk);
        end

        // Frame 3: pause after pixel 15, write attempt while busy.
        pulse_start(8'd0);
        wait_pix(8'd15, "f3 pixel 15");
        bus.pause   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(5);
        bus.wr_data = 8'hFF;
        @(negedge clk);
        bus.wr_en = 1'b0;
        chk("pause1 valid", bus.valid_out, 1'b0);
        chk("pause1 hold",  bus.pixel_out, 8'd15);
        @(negedge clk);
        chk("pause2 valid", bus.valid_out, 1'b0);
        chk("pause2 hold",  bus.pixel_out, 8'd15);
        bus.pause = 1'b0;
        @(negedge clk);
        chk("resume valid", bus.valid_out, 1'b1);
        chk("resume pixel", bus.pixel_out, 8'd16);
        wait_last("f3 last");
        @(negedge clk);

        // Frame 4: reset at pixel 17, then replay from the top.
        pulse_start(8'd0);
        wait_pix(8'd17, "f4 pixel 17");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid rst valid", bus.valid_out, 1'b0);
        chk("mid rst busy",  bus.busy,      1'b0);
        @(negedge clk);
        pulse_start(8'd0);
        @(negedge clk);
        chk("replay first pixel", bus.pixel_out, 8'd10);
        chk("replay sof",         bus.sof_out,   1'b1);
        repeat (5) @(negedge clk);
        chk("replay addr5 kept",  bus.pixel_out, 8'd15);
        wait_last("f4 last");
        @(negedge clk);

        // Frame 5/6: start held across last_out -> one idle cycle.
        bus.row_gap = 8'd0;
        bus.start   = 1'b1;
        wait_last("b2b first last");
        chk("b2b busy at last", bus.busy, 1'b0);
        @(negedge clk);
        chk("b2b idle cycle", bus.valid_out, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b second pixel", bus.pixel_out, 8'd10);
        chk("b2b second sof",   bus.sof_out,   1'b1);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_last("b2b second last");
        @(negedge clk);
        chk("no restart valid", bus.valid_out, 1'b0);
        chk("no restart busy",  bus.busy,      1'b0);

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            bus.pause   = ($urandom_range(0, 3) == 0);
            bus.start   = ($urandom_range(0, 7) == 0);
            bus.row_gap = 8'($urandom_range(0, 4));
            bus.wr_en   = ($urandom_range(0, 5) == 0);
            bus.wr_addr = AW'($urandom_range(0, 15));
            bus.wr_data = 8'($urandom);
            rst         = ($urandom_range(0, 299) == 0);
            if (rst) bus.wr_en = 1'b0;
            @(negedge clk);
        end
        rst       = 1'b0;
        bus.pause = 1'b0;
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        repeat (60) @(negedge clk);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pixel_stream_source.md
Name: pixel_stream_source

Overview:
Frame-buffered pixel transmitter that drives the raster pixel stream consumed by the Sobel pipeline (valid/8-bit pixel, row-major, no backpressure). A host loads one frame through a simple write port. On a start pulse the block replays the frame pixel by pixel. Programmable inter-row idle gaps and a pause input deliberately exercise the consumer's handling of valid_in low.

Parameters:
WIDTH, 128, pixels per row
HEIGHT, 128, rows per frame
ADDR_W, 14, frame-memory address width; must satisfy 2**ADDR_W >= WIDTH*HEIGHT

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
wr_en  in  1  frame-memory write strobe
wr_addr  in  ADDR_W  linear write address (row*WIDTH+col)
wr_data  in  8  pixel to store
start  in  1  begin streaming one frame (level sampled in IDLE)
row_gap  in  8  idle cycles inserted after each row except the last
pause  in  1  hold stream: no pixel emitted, counters frozen
valid_out  out  1  pixel_out valid this cycle
pixel_out  out  8  pixel data
sof_out  out  1  high with pixel (0,0)
eol_out  out  1  high with the last pixel of every row
last_out  out  1  high with the final pixel of the frame
busy  out  1  high while state != IDLE

Behaviour:
- Storage: WIDTH*HEIGHT x 8 memory. Not reset; contents survive rst.
- Writes: accepted only when busy=0 and wr_addr < WIDTH*HEIGHT. Otherwise the write is ignored.
- Memory read: synchronous, registered directly into pixel_out.
- Reset values: valid_out=0, pixel_out=0, sof_out=0, eol_out=0, last_out=0, busy=0; state=IDLE; col=0, row=0, gap count=0.
- FSM states:
  - IDLE: start=1 at edge k -> STREAM; clear col/row; latch row_gap into gap_len. row_gap is ignored outside this moment.
  - STREAM: at each edge with pause=0:
    - pixel_out <= mem[row*WIDTH+col]; valid_out <= 1.
    - sof_out <= (row==0 && col==0); eol_out <= (col==WIDTH-1); last_out <= (col==WIDTH-1 && row==HEIGHT-1).
    - col increments.
    - At col==WIDTH-1: col wraps to 0 and row increments. Next state: IDLE if row==HEIGHT-1; GAP if gap_len!=0; else stay in STREAM.
  - STREAM with pause=1: valid_out/sof/eol/last <= 0; pixel_out holds; col/row hold.
  - GAP: valid_out <= 0; gap counter counts gap_len cycles and ignores pause, then -> STREAM.
- Latency: start sampled at edge k -> pixel (0,0) valid after edge k+1.
- Throughput: with pause=0 and gap_len=0 the stream is contiguous, WIDTH*HEIGHT consecutive valid cycles.
- Flag timing: sof/eol/last are single-cycle and qualified by valid_out. busy drops in the cycle last_out=1.
- Back-to-back frames: start=1 in the last_out cycle is accepted. It yields exactly one idle cycle between frames.
- start while busy: ignored, no restart.
- Reset mid-frame: on the next edge all outputs return to reset values and state=IDLE; the partial frame is abandoned.
- Counter widths: col is $clog2(WIDTH) bits, row is $clog2(HEIGHT) bits. Address arithmetic is ADDR_W bits and must not overflow.

Test Plan:
- WIDTH=4, HEIGHT=3, load mem[i]=i+10, row_gap=0, pulse start -> 12 consecutive valid cycles with pixel_out 10..21, starting one cycle after the start edge. sof with 10; eol with 13, 17, 21; last with 21; busy low on 21's cycle.
- Same frame, row_gap=3 -> exactly 3 valid_out=0 cycles after pixels 13 and 17, none after 21. Total frame span is 18 cycles.
- pause high for 2 cycles after pixel 15 -> two invalid cycles, then pixel 16 resumes. No pixel skipped or duplicated, pixel_out held during pause.
- wr_en during streaming (addr 5, data 0xFF) and wr_addr=12 while idle -> both ignored. Replay still gives 15 at addr 5.
- rst asserted for one cycle at pixel 17 -> valid_out=0 next cycle, busy=0. A subsequent start replays from pixel 10 with memory intact.
- start held high across last_out -> second frame's pixel 10 appears after a single idle cycle. start pulses during streaming have no effect.
